hit_resolver: RTL and testbench

//  Responder side of the attack path: consumes each player's attack window, position and facing.

---
 rtl/fighter_pkg.sv | 73 +++++++
 rtl/hit_defender.sv | 87 ++++++++
 rtl/hit_resolver.sv | 127 ++++++++++++
 tb/tb_hit_resolver.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
// Shared fighter constants: hitbox/hurtbox geometry, health defaults, winner codes, defender states.
// Box helpers work in 12-bit signed so left-facing offsets can go negative before clamping.
// Ports: none (package).
package fighter_pkg;

    localparam int MAX_HEALTH_DEF     = 100;
    localparam int DAMAGE_DEF         = 10;
    localparam int HITSTUN_FRAMES_DEF = 20;
    localparam int HEALTH_W           = 7;
    localparam int CNT_W              = 8;

    localparam logic signed [11:0] HIT_OFS_F  =  12'sd85;
    localparam logic signed [11:0] HIT_OFS_B  = -12'sd5;
    localparam logic signed [11:0] HIT_OFS_Y  = -12'sd5;
    localparam logic signed [11:0] HIT_W      =  12'sd40;
    localparam logic signed [11:0] HIT_H      =  12'sd80;
    localparam logic signed [11:0] HURT_OFS_X =  12'sd40;
    localparam logic signed [11:0] HURT_OFS_Y =  12'sd53;
    localparam logic signed [11:0] HURT_W     =  12'sd40;
    localparam logic signed [11:0] HURT_H     =  12'sd45;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_HITSTUN = 2'd1,
        ST_KO      = 2'd2
    } def_state_e;

    typedef struct packed {
        logic signed [11:0] x0;
        logic signed [11:0] y0;
        logic signed [11:0] x1;
        logic signed [11:0] y1;
    } box_t;

    // Attacker hitbox; x0 is clamped at the left screen edge and the width
    // is measured from the clamped edge.
    function automatic box_t hit_box(input logic [9:0] px, input logic [9:0] py,
                                     input logic facing);
        logic signed [11:0] x0;
        logic signed [11:0] y0;
        x0 = $signed({2'b00, px}) + (facing ? HIT_OFS_F : HIT_OFS_B);
        if (x0[11]) begin
            x0 = '0;
        end
        y0 = $signed({2'b00, py}) + HIT_OFS_Y;
        hit_box.x0 = x0;
        hit_box.y0 = y0;
        hit_box.x1 = x0 + HIT_W;
        hit_box.y1 = y0 + HIT_H;
    endfunction

    function automatic box_t hurt_box(input logic [9:0] px, input logic [9:0] py);
        logic signed [11:0] x0;
        logic signed [11:0] y0;
        x0 = $signed({2'b00, px}) + HURT_OFS_X;
        y0 = $signed({2'b00, py}) + HURT_OFS_Y;
        hurt_box.x0 = x0;
        hurt_box.y0 = y0;
        hurt_box.x1 = x0 + HURT_W;
        hurt_box.y1 = y0 + HURT_H;
    endfunction

    // Strict overlap: boxes that only share an edge do not touch.
    function automatic logic boxes_overlap(input box_t a, input box_t b);
        boxes_overlap = (a.x0 < b.x1) && (b.x0 < a.x1) && (a.y0 < b.y1) && (b.y0 < a.y1);
    endfunction

endpackage

// File: rtl/hit_defender.sv
// Per-player defender: ALIVE/HITSTUN/KO state, hitstun countdown and health, stepped on frame strobe.
// Ports: clk/reset_n; scen_i frame strobe; restart_i round restart; freeze_i game over; hit_i gated hit;
//        health_o, hitstun_o, hit_pulse_o (registered), alive_o and ko_now_o (combinational helpers).
module hit_defender
    import fighter_pkg::*;
#(
    parameter int MAX_HEALTH     = MAX_HEALTH_DEF,
    parameter int DAMAGE         = DAMAGE_DEF,
    parameter int HITSTUN_FRAMES = HITSTUN_FRAMES_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                scen_i,
    input  logic                restart_i,
    input  logic                freeze_i,
    input  logic                hit_i,
    output logic [HEALTH_W-1:0] health_o,
    output logic                hitstun_o,
    output logic                hit_pulse_o,
    output logic                alive_o,
    output logic                ko_now_o
);

    localparam logic [HEALTH_W-1:0] HP_MAX    = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0] DMG       = HEALTH_W'(DAMAGE);
    localparam logic [CNT_W-1:0]    STUN_LAST = CNT_W'(HITSTUN_FRAMES - 1);

    def_state_e          state_q;
    logic [HEALTH_W-1:0] health_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                hitstun_q;
    logic                hit_pulse_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_ALIVE;
            health_q    <= HP_MAX;
            cnt_q       <= '0;
            hitstun_q   <= 1'b0;
            hit_pulse_q <= 1'b0;
        end else begin
            hit_pulse_q <= 1'b0;
            if (scen_i) begin
                if (restart_i) begin
                    state_q   <= ST_ALIVE;
                    health_q  <= HP_MAX;
                    cnt_q     <= '0;
                    hitstun_q <= 1'b0;
                end else if (!freeze_i) begin
                    case (state_q)
                        ST_ALIVE: begin
                            if (hit_i) begin
                                hit_pulse_q <= 1'b1;
                                if (health_q > DMG) begin
                                    state_q   <= ST_HITSTUN;
                                    cnt_q     <= STUN_LAST;
                                    health_q  <= health_q - DMG;
                                    hitstun_q <= 1'b1;
                                end else begin
                                    state_q  <= ST_KO;
                                    health_q <= '0;
                                end
                            end
                        end
                        ST_HITSTUN: begin
                            if (cnt_q == '0) begin
                                state_q   <= ST_ALIVE;
                                hitstun_q <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q - 1'b1;
                            end
                        end
                        default: ;  // ST_KO holds until restart or reset
                    endcase
                end
            end
        end
    end

    assign health_o    = health_q;
    assign hitstun_o   = hitstun_q;
    assign hit_pulse_o = hit_pulse_q;
    assign alive_o     = (state_q == ST_ALIVE);
    // The top uses this to decide game over in the same frame as the finishing blow.
    assign ko_now_o    = hit_i && (health_q <= DMG);

endmodule

// File: rtl/hit_resolver.sv
// Frame-stepped hit resolution for two fighters: box overlap, one-hit-per-swing latches, KO and winner.
// Ports: clk, reset_n, SCEN, round_restart; per player pos/facing/attack_active/attack_damage in,
//        hitstun_active/health/hit_pulse out; game_over and winner out. All outputs registered.
module hit_resolver
    import fighter_pkg::*;
#(
    parameter int MAX_HEALTH     = MAX_HEALTH_DEF,
    parameter int DAMAGE         = DAMAGE_DEF,
    parameter int HITSTUN_FRAMES = HITSTUN_FRAMES_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                SCEN,
    input  logic                round_restart,
    input  logic [9:0]          p1_pos_x,
    input  logic [9:0]          p1_pos_y,
    input  logic                p1_facing,
    input  logic                p1_attack_active,
    input  logic                p1_attack_damage,
    input  logic [9:0]          p2_pos_x,
    input  logic [9:0]          p2_pos_y,
    input  logic                p2_facing,
    input  logic                p2_attack_active,
    input  logic                p2_attack_damage,
    output logic                p1_hitstun_active,
    output logic [HEALTH_W-1:0] p1_health,
    output logic                p1_hit_pulse,
    output logic                p2_hitstun_active,
    output logic [HEALTH_W-1:0] p2_health,
    output logic                p2_hit_pulse,
    output logic                game_over,
    output logic [1:0]          winner
);

    box_t hb1, hb2, hu1, hu2;
    logic p1_alive, p2_alive;
    logic p1_ko_now, p2_ko_now;
    logic p1_lands, p2_lands;      // attacker N lands a hit this frame
    logic [1:0] latch_q, latch_d;  // bit0 = P1 swing already connected, bit1 = P2
    logic       game_over_q, game_over_d;
    logic [1:0] winner_q, winner_d;

    assign hb1 = hit_box(p1_pos_x, p1_pos_y, p1_facing);
    assign hb2 = hit_box(p2_pos_x, p2_pos_y, p2_facing);
    assign hu1 = hurt_box(p1_pos_x, p1_pos_y);
    assign hu2 = hurt_box(p2_pos_x, p2_pos_y);

    // Restart wins over hit evaluation in the same frame.
    assign p1_lands = SCEN && !round_restart && !game_over_q && p1_attack_damage
                      && !latch_q[0] && p2_alive && boxes_overlap(hb1, hu2);
    assign p2_lands = SCEN && !round_restart && !game_over_q && p2_attack_damage
                      && !latch_q[1] && p1_alive && boxes_overlap(hb2, hu1);

    always_comb begin
        latch_d     = latch_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        if (SCEN) begin
            if (round_restart) begin
                // Swings already underway at restart must end before they can score.
                latch_d     = 2'b11;
                game_over_d = 1'b0;
                winner_d    = WIN_NONE;
            end else if (!game_over_q) begin
                latch_d[0] = p1_lands || (latch_q[0] && p1_attack_active);
                latch_d[1] = p2_lands || (latch_q[1] && p2_attack_active);
                if (p1_ko_now || p2_ko_now) begin
                    game_over_d = 1'b1;
                    // Bit 0 = P1 survives, bit 1 = P2 survives; double KO gives draw.
                    winner_d    = {p1_ko_now, p2_ko_now};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            latch_q     <= '0;
            game_over_q <= 1'b0;
            winner_q    <= WIN_NONE;
        end else begin
            latch_q     <= latch_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    hit_defender #(
        .MAX_HEALTH    (MAX_HEALTH),
        .DAMAGE        (DAMAGE),
        .HITSTUN_FRAMES(HITSTUN_FRAMES)
    ) u_def_p1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .scen_i     (SCEN),
        .restart_i  (round_restart),
        .freeze_i   (game_over_q),
        .hit_i      (p2_lands),
        .health_o   (p1_health),
        .hitstun_o  (p1_hitstun_active),
        .hit_pulse_o(p1_hit_pulse),
        .alive_o    (p1_alive),
        .ko_now_o   (p1_ko_now)
    );

    hit_defender #(
        .MAX_HEALTH    (MAX_HEALTH),
        .DAMAGE        (DAMAGE),
        .HITSTUN_FRAMES(HITSTUN_FRAMES)
    ) u_def_p2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .scen_i     (SCEN),
        .restart_i  (round_restart),
        .freeze_i   (game_over_q),
        .hit_i      (p1_lands),
        .health_o   (p2_health),
        .hitstun_o  (p2_hitstun_active),
        .hit_pulse_o(p2_hit_pulse),
        .alive_o    (p2_alive),
        .ko_now_o   (p2_ko_now)
    );

    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_hit_resolver.sv
// Bench for hit_resolver: geometry vector table, hand-written multi-frame sequences,
// and a randomized run against a frame-level behavioural model.
// Ports: none (top-level bench).
module tb_hit_resolver;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       SCEN = 1'b0;
    logic       round_restart = 1'b0;
    logic [9:0] px[2];
    logic [9:0] py[2];
    logic       fac[2];
    logic       act[2];
    logic       dmg[2];
    logic [6:0] hp[2];
    logic       hs[2];
    logic       pulse[2];
    logic       game_over;
    logic [1:0] winner;

    int total = 0;
    int passed = 0;

    always #20 clk = ~clk;

    hit_resolver dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .SCEN             (SCEN),
        .round_restart    (round_restart),
        .p1_pos_x         (px[0]),
        .p1_pos_y         (py[0]),
        .p1_facing        (fac[0]),
        .p1_attack_active (act[0]),
        .p1_attack_damage (dmg[0]),
        .p2_pos_x         (px[1]),
        .p2_pos_y         (py[1]),
        .p2_facing        (fac[1]),
        .p2_attack_active (act[1]),
        .p2_attack_damage (dmg[1]),
        .p1_hitstun_active(hs[0]),
        .p1_health        (hp[0]),
        .p1_hit_pulse     (pulse[0]),
        .p2_hitstun_active(hs[1]),
        .p2_health        (hp[1]),
        .p2_hit_pulse     (pulse[1]),
        .game_over        (game_over),
        .winner           (winner)
    );

    task automatic chk(input string nm, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, actual, expected);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        SCEN = 1'b0;
        round_restart = 1'b0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; dmg[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One frame: SCEN high for one clk; outputs are sampled on the negedge after the update.
    task automatic frame();
        @(negedge clk);
        SCEN = 1'b1;
        @(negedge clk);
        SCEN = 1'b0;
    endtask

    task automatic place(input int x1, input int y1, input bit f1,
                         input int x2, input int y2, input bit f2);
        px[0] = 10'(x1); py[0] = 10'(y1); fac[0] = f1;
        px[1] = 10'(x2); py[1] = 10'(y2); fac[1] = f2;
    endtask

    task automatic swing(input int p, input bit on);
        act[p] = on; dmg[p] = on;
    endtask

    // ---------------- behavioural reference model ----------------
    int m_hp[2];
    int m_stun[2];   // frames of hitstun remaining
    bit m_ko[2];
    bit m_latch[2];
    bit m_pulse[2];
    bit m_go;
    int m_win;

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_hp[i] = 100; m_stun[i] = 0; m_ko[i] = 0; m_latch[i] = 0; m_pulse[i] = 0;
        end
        m_go = 0; m_win = 0;
    endtask

    function automatic bit m_overlap(input int a, input int d);
        int ax0, ax1, ay0, ay1, bx0, bx1, by0, by1;
        ax0 = fac[a] ? int'(px[a]) + 85 : int'(px[a]) - 5;
        if (ax0 < 0) ax0 = 0;
        ax1 = ax0 + 40;
        ay0 = int'(py[a]) - 5;
        ay1 = ay0 + 80;
        bx0 = int'(px[d]) + 40; bx1 = bx0 + 40;
        by0 = int'(py[d]) + 53; by1 = by0 + 45;
        return (ax0 < bx1) && (bx0 < ax1) && (ay0 < by1) && (by0 < ay1);
    endfunction

    task automatic m_frame();
        bit lands[2];
        m_pulse[0] = 0; m_pulse[1] = 0;
        if (round_restart) begin
            m_reset();
            m_latch[0] = 1; m_latch[1] = 1;
        end else if (!m_go) begin
            for (int a = 0; a < 2; a++)
                lands[a] = dmg[a] && m_overlap(a, 1 - a) && !m_latch[a]
                           && !m_ko[1 - a] && m_stun[1 - a] == 0;
            for (int d = 0; d < 2; d++) begin
                if (lands[1 - d]) begin
                    m_pulse[d] = 1;
                    if (m_hp[d] > 10) begin m_hp[d] -= 10; m_stun[d] = 20; end
                    else begin m_hp[d] = 0; m_ko[d] = 1; end
                end else if (m_stun[d] > 0) m_stun[d]--;
            end
            for (int a = 0; a < 2; a++)
                if (lands[a]) m_latch[a] = 1;
                else if (!act[a]) m_latch[a] = 0;
            if (m_ko[0] || m_ko[1]) begin
                m_go = 1;
                m_win = (m_ko[1] ? 1 : 0) + (m_ko[0] ? 2 : 0);
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int p1x; int p1y; bit p1f; bit p1d;
        int p2x; int p2y; bit p2f; bit p2d;
        int eh1; int eh2;
    } vec_t;
    vec_t vt[13];

    initial begin
        int n;
        int pulses;
        vt[0]  = '{100, 285, 1, 1, 160, 285, 0, 0, 100,  90};  // basic hit
        vt[1]  = '{100, 285, 1, 1, 300, 285, 0, 0, 100, 100};  // out of range
        vt[2]  = '{250, 285, 0, 1, 200, 285, 0, 0, 100,  90};  // facing left
        vt[3]  = '{100, 285, 1, 1, 185, 285, 0, 0, 100, 100};  // x edges touch only
        vt[4]  = '{100, 285, 1, 1, 184, 285, 0, 0, 100,  90};  // 1 px overlap in x
        vt[5]  = '{100, 285, 1, 1, 160, 307, 0, 0, 100, 100};  // bottom edge touch
        vt[6]  = '{100, 285, 1, 1, 160, 306, 0, 0, 100,  90};
        vt[7]  = '{100, 285, 1, 1, 160, 182, 0, 0, 100, 100};  // top edge touch
        vt[8]  = '{100, 285, 1, 1, 160, 183, 0, 0, 100,  90};
        vt[9]  = '{100, 285, 1, 1, 160, 285, 0, 1,  90,  90};  // trade
        vt[10] = '{  2, 285, 0, 1,   0, 285, 0, 0, 100, 100};  // clamped hitbox at screen edge
        vt[11] = '{100, 285, 1, 0, 160, 285, 0, 0, 100, 100};  // swing without live window
        vt[12] = '{250, 285, 0, 0, 200, 285, 1, 1,  90, 100};  // P2 attacks

        place(100, 285, 1, 160, 285, 0);

        // Reset state
        do_reset();
        chk("reset_p1_health", hp[0], 100);
        chk("reset_p2_health", hp[1], 100);
        chk("reset_hitstun", {hs[0], hs[1]}, 0);
        chk("reset_winner", winner, 0);
        chk("reset_game_over", game_over, 0);

        // Geometry table
        foreach (vt[i]) begin
            do_reset();
            place(vt[i].p1x, vt[i].p1y, vt[i].p1f, vt[i].p2x, vt[i].p2y, vt[i].p2f);
            act[0] = 1'b1; dmg[0] = vt[i].p1d;
            act[1] = vt[i].p2d; dmg[1] = vt[i].p2d;
            frame();
            chk($sformatf("vec%0d_p1_health", i), hp[0], vt[i].eh1);
            chk($sformatf("vec%0d_p2_health", i), hp[1], vt[i].eh2);
            chk($sformatf("vec%0d_p2_pulse", i), pulse[1], (vt[i].eh2 < 100) ? 1 : 0);
        end

        // Single hit: pulse one clk, hitstun lasts 20 frames
        do_reset();
        place(100, 285, 1, 160, 285, 0);
        swing(0, 1);
        frame();
        swing(0, 0);
        chk("hit_health", hp[1], 90);
        chk("hit_pulse_high", pulse[1], 1);
        chk("hit_stun_on", hs[1], 1);
        @(negedge clk);
        chk("hit_pulse_one_clk", pulse[1], 0);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            frame();
            if (!hs[1]) begin n = k; break; end
        end
        chk("hitstun_frames", n, 20);

        // Reset in mid-hitstun
        swing(0, 1);
        frame();
        swing(0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midstun_reset_health", hp[1], 100);
        chk("midstun_reset_stun", hs[1], 0);

        // Long swing lands only once
        do_reset();
        pulses = 0;
        swing(0, 1);
        for (int k = 0; k < 25; k++) begin
            frame();
            pulses += pulse[1];
        end
        swing(0, 0);
        chk("long_swing_health", hp[1], 90);
        chk("long_swing_pulses", pulses, 1);

        // Trades down to double KO
        do_reset();
        for (int t = 0; t < 9; t++) begin
            swing(0, 1); swing(1, 1);
            frame();
            swing(0, 0); swing(1, 0);
            repeat (21) frame();
        end
        chk("trade_p1_at_10", hp[0], 10);
        chk("trade_p2_at_10", hp[1], 10);
        swing(0, 1); swing(1, 1);
        frame();
        swing(0, 0); swing(1, 0);
        chk("double_ko_p1", hp[0], 0);
        chk("double_ko_p2", hp[1], 0);
        chk("double_ko_winner", winner, 3);
        chk("double_ko_game_over", game_over, 1);

        // P2 beaten down, then hits frozen
        do_reset();
        for (int t = 0; t < 10; t++) begin
            swing(0, 1);
            frame();
            swing(0, 0);
            repeat (21) frame();
        end
        chk("ko_p2_health", hp[1], 0);
        chk("ko_game_over", game_over, 1);
        chk("ko_winner", winner, 1);
        swing(1, 1);
        frame();
        swing(1, 0);
        chk("frozen_p1_health", hp[0], 100);
        chk("frozen_p1_pulse", pulse[0], 0);
        chk("frozen_winner", winner, 1);

        // Round restart while P1 swing is live
        do_reset();
        swing(0, 1);
        frame();
        chk("pre_restart_health", hp[1], 90);
        round_restart = 1'b1;
        frame();
        round_restart = 1'b0;
        chk("restart_health", hp[1], 100);
        chk("restart_pulse", pulse[1], 0);
        chk("restart_stun", hs[1], 0);
        repeat (25) frame();
        chk("restart_latch_holds", hp[1], 100);
        swing(0, 0);
        frame();
        swing(0, 1);
        frame();
        swing(0, 0);
        chk("restart_new_swing", hp[1], 90);

        // Randomized run against the model
        do_reset();
        m_reset();
        for (int f = 0; f < 700; f++) begin
            px[0] = 10'(80 + $urandom_range(0, 100));
            px[1] = px[0] + 10'($urandom_range(0, 160)) - 10'd20;
            py[0] = 10'(250 + $urandom_range(0, 60));
            py[1] = 10'(250 + $urandom_range(0, 60));
            fac[0] = ($urandom_range(0, 4) != 0);
            fac[1] = ($urandom_range(0, 4) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!act[p]) act[p] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 5) == 0) act[p] = 1'b0;
                dmg[p] = act[p] && ($urandom_range(0, 2) != 0);
            end
            round_restart = ($urandom_range(0, 79) == 0);
            frame();
            m_frame();
            round_restart = 1'b0;
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rnd%0d_health%0d", f, p + 1), hp[p], m_hp[p]);
                chk($sformatf("rnd%0d_stun%0d", f, p + 1), hs[p], (m_stun[p] > 0) ? 1 : 0);
                chk($sformatf("rnd%0d_pulse%0d", f, p + 1), pulse[p], m_pulse[p]);
            end
            chk($sformatf("rnd%0d_game_over", f), game_over, m_go);
            chk($sformatf("rnd%0d_winner", f), winner, m_win);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk($sformatf("rnd%0d_idle_pulse", f), {pulse[0], pulse[1]}, 0);
                chk($sformatf("rnd%0d_idle_health", f), {hp[0], hp[1]}, {7'(m_hp[0]), 7'(m_hp[1])});
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
